ad7794_spi_master: RTL and testbench
====================================

# ad7794_spi_master

SPI transaction engine for the Zest AD7794 thermometer/monitor ADC (U18). It sits directly upstream of the Zest carrier pin mapping and drives its `U18_CS`, `U18_SCLK`, `U18_DIN` and `U18_CLK` lines. It samples `U18_DOUT_RDY`. A host issues one command byte plus 0-3 data bytes per transaction, optionally waiting first for the conversion-ready indication, with timeout.

## Interface
Parameters:
- `CLK_DIV`, 8: SCLK half-period in `clk` cycles; legal range 4..255.
- `TIMEOUT_W`, 20: width of the RDY-wait counter; the timeout fires after 2^TIMEOUT_W−1 cycles.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `start`  in  1  single-cycle request; accepted only when `busy`=0.
- `cmd`  in  8  communications-register byte, shifted MSB first.
- `wdata`  in  24  write payload, right-justified; the top `nbytes`×8 bits of the used field are sent MSB first.
- `nbytes`  in  2  number of data bytes after `cmd` (0-3).
- `rd`  in  1  1 = data phase is a read: DIN held high and DOUT captured.
- `wait_rdy`  in  1  1 = after CS falls, wait for `U18_DOUT_RDY`=0 before shifting.
- `busy`  out  1  transaction in progress.
- `done`  out  1  one-cycle pulse at transaction end.
- `err`  out  1  last transaction timed out; valid with `done`, held until the next accepted `start`.
- `rdata`  out  24  read result, right-justified.
- `U18_CS`  out  1  chip select, active-low.
- `U18_SCLK`  out  1  serial clock; idles high (SPI mode 3).
- `U18_DIN`  out  1  serial data to the ADC.
- `U18_CLK`  out  1  external MCLK; tied 0 (internal oscillator used).
- `U18_DOUT_RDY`  in  1  serial data / ready from the ADC; asynchronous.

## Operation
- `U18_DOUT_RDY` passes through a 2-flop synchronizer. All uses of it below refer to the synchronized value.
- `start`, `cmd`, `wdata`, `nbytes`, `rd` and `wait_rdy` are registered on acceptance. Later input changes have no effect.
- States:
  - IDLE: `start` -> SETUP, with `busy`=1 and `err`=0.
  - SETUP: `U18_CS`=0 for CLK_DIV cycles; then -> WAIT if `wait_rdy`, else -> SHIFT.
  - WAIT: counts up. RDY=0 -> SHIFT. Counter reaches all-ones -> HOLD with the err flag set and no bits shifted.
  - SHIFT: 8+8×`nbytes` bits, then -> HOLD.
  - HOLD: CS stays low CLK_DIV cycles, then CS goes high -> GAP.
  - GAP: CS high for CLK_DIV cycles, then -> IDLE. `done` pulses in the cycle of that transition.
- Each bit lasts 2×CLK_DIV cycles: SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - DIN updates on the cycle SCLK falls.
  - DOUT is sampled on the last cycle of the high phase.
- Command byte: DIN = `cmd` MSB first.
- Data bytes, write (`rd`=0): DIN = `wdata[8×nbytes−1:0]` MSB first.
- Data bytes, read (`rd`=1): DIN=1 and the sampled bits are shifted into `rdata` LSB-in.
  - At `done`, `rdata` holds the last 8×`nbytes` bits; the upper bits are 0.
  - `rdata` is not modified when `rd`=0, when `nbytes`=0, or on timeout.
- `start` while `busy`=1 is ignored and is not queued.
- `nbytes`=0 gives a command-only transaction of 8 bits.
- Timeout: `done` and `err` are both 1. `rdata` is unchanged.

## Timing
- Reset values: `U18_CS`=1, `U18_SCLK`=1, `U18_DIN`=1, `U18_CLK`=0, `busy`=0, `done`=0, `err`=0, `rdata`=0, state IDLE.
- `rst_n` low mid-transaction returns all outputs to their reset values on the next `clk` edge. No further SCLK edges are produced.
- With `start` sampled at edge 0:
  - `busy` and CS=0 from cycle 1.
  - First SCLK fall at cycle 1+CLK_DIV, plus the WAIT duration when `wait_rdy`=1.
- Latency without wait: N = 8×(1+`nbytes`) bits. `done` is at cycle 1 + CLK_DIV + 2N×CLK_DIV + CLK_DIV + CLK_DIV.
- `busy` drops in the same cycle `done` pulses. `start` is accepted in that same cycle, and the next CS fall is 1 cycle later.
- The WAIT exit in response to RDY falling has latency ≤ 3 cycles: 2 synchronizer cycles plus 1 state cycle.

## Test plan
- CLK_DIV=4, `cmd`=0x10, `nbytes`=2, `wdata`=0x004012, `rd`=0, `wait_rdy`=0:
  - DIN bit stream 0x10,0x40,0x12 MSB first, with 24 SCLK rising edges.
  - `done` at cycle 205; CS low for cycles 1-200.
  - `rdata` stays 0.
- CLK_DIV=4, `cmd`=0x58, `nbytes`=3, `rd`=1, ADC model returning 0xA5C3F0:
  - `rdata`=0xA5C3F0 at `done`.
  - DIN=1 throughout the data bytes.
- `wait_rdy`=1, RDY driven low 500 cycles after CS falls:
  - No SCLK edge before RDY low plus 3 cycles.
  - The transfer then completes with `err`=0.
- TIMEOUT_W=6, `wait_rdy`=1, RDY held high:
  - `done` with `err`=1 after 63 WAIT cycles.
  - Zero SCLK edges; `rdata` unchanged.
- `start` pulses during `busy`, and `rst_n`=0 asserted mid-SHIFT:
  - Extra starts are ignored.
  - On reset, outputs are at reset values the next cycle and the SCLK edge count is frozen.
- `nbytes`=0, `cmd`=0xFF, repeated back-to-back by asserting `start` on `done`:
  - 8 SCLK edges per transaction.
  - CS high for exactly CLK_DIV+1 cycles between transactions.

Source files
------------

// File: rtl/ad7794_spi_master_if.sv
// Host-side transaction bus for the AD7794 SPI engine: request fields in,
// status and read result out.
interface ad7794_spi_master_if;
  logic        start;
  logic [7:0]  cmd;
  logic [23:0] wdata;
  logic [1:0]  nbytes;
  logic        rd;
  logic        wait_rdy;
  logic        busy;
  logic        done;
  logic        err;
  logic [23:0] rdata;

  modport master (
    output start, cmd, wdata, nbytes, rd, wait_rdy,
    input  busy, done, err, rdata
  );

  modport slave (
    input  start, cmd, wdata, nbytes, rd, wait_rdy,
    output busy, done, err, rdata
  );
endinterface

// File: rtl/ad7794_spi_master.sv
// SPI transaction engine for the Zest AD7794 (U18): one command byte plus
// 0-3 data bytes, SPI mode 3, optional wait for DOUT/RDY low with timeout.
// Every pin and status output comes straight from a flop.
module ad7794_spi_master #(
  parameter int CLK_DIV   = 8,
  parameter int TIMEOUT_W = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ad7794_spi_master_if.slave   bus,
  output logic                 U18_CS,
  output logic                 U18_SCLK,
  output logic                 U18_DIN,
  output logic                 U18_CLK,
  input  logic                 U18_DOUT_RDY
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

  localparam logic [7:0]           DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [TIMEOUT_W-1:0] WCNT_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  // Place the used low nbytes*8 bits of the payload at the top of the field,
  // so the transmit register can always shift out of its MSB.
  function automatic logic [23:0] left_justify(input logic [23:0] data,
                                               input logic [1:0]  n);
    logic [23:0] res;
    case (n)
      2'd0:    res = 24'h000000;
      2'd1:    res = {data[7:0], 16'h0000};
      2'd2:    res = {data[15:0], 8'h00};
      default: res = data;
    endcase
    return res;
  endfunction

  state_t                state_r, state_s;
  logic [7:0]            div_r, div_s;
  logic [4:0]            bit_r, bit_s;
  logic [TIMEOUT_W-1:0]  wcnt_r, wcnt_s, wcnt_inc_s;
  logic [31:0]           tx_r, tx_s;
  logic [23:0]           rx_r, rx_s;
  logic [1:0]            nbytes_r, nbytes_s;
  logic                  rd_r, rd_s;
  logic                  wait_r, wait_s;
  logic                  cs_r, cs_s;
  logic                  sclk_r, sclk_s;
  logic                  din_r, din_s;
  logic                  busy_r, busy_s;
  logic                  done_r, done_s;
  logic                  err_r, err_s;
  logic [23:0]           rdata_r, rdata_s;
  logic                  rdy_meta_r, rdy_sync_r;
  logic [4:0]            bit_last_s;

  // Two-flop synchronizer for the asynchronous DOUT/RDY pin; idles high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdy_meta_r <= 1'b1;
      rdy_sync_r <= 1'b1;
    end else begin
      rdy_meta_r <= U18_DOUT_RDY;
      rdy_sync_r <= rdy_meta_r;
    end
  end

  // Index of the final bit of the frame: 8 + 8*nbytes - 1.
  assign bit_last_s = {nbytes_r, 3'b111};
  assign wcnt_inc_s = wcnt_r + WCNT_ONE;

  // Next-state and next-output logic for the transaction sequencer.
  always_comb begin
    state_s  = state_r;
    div_s    = div_r;
    bit_s    = bit_r;
    wcnt_s   = wcnt_r;
    tx_s     = tx_r;
    rx_s     = rx_r;
    nbytes_s = nbytes_r;
    rd_s     = rd_r;
    wait_s   = wait_r;
    cs_s     = cs_r;
    sclk_s   = sclk_r;
    din_s    = din_r;
    busy_s   = busy_r;
    done_s   = 1'b0;
    err_s    = err_r;
    rdata_s  = rdata_r;

    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_s  = ST_SETUP;
          busy_s   = 1'b1;
          err_s    = 1'b0;
          cs_s     = 1'b0;
          div_s    = 8'd0;
          bit_s    = 5'd0;
          wcnt_s   = '0;
          nbytes_s = bus.nbytes;
          rd_s     = bus.rd;
          wait_s   = bus.wait_rdy;
          // A read keeps DIN high through the data bytes.
          tx_s     = {bus.cmd, bus.rd ? 24'hFFFFFF : left_justify(bus.wdata, bus.nbytes)};
          rx_s     = 24'h000000;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_SETUP: begin
        if (div_r == DIV_LAST) begin
          div_s = 8'd0;
          if (wait_r) begin
            state_s = ST_WAIT;
          end else begin
            state_s = ST_SHIFT;
            sclk_s  = 1'b0;
            din_s   = tx_r[31];
            tx_s    = {tx_r[30:0], 1'b0};
          end
        end else begin
          div_s = div_r + 8'd1;
        end
      end

      ST_WAIT: begin
        if (!rdy_sync_r) begin
          state_s = ST_SHIFT;
          sclk_s  = 1'b0;
          din_s   = tx_r[31];
          tx_s    = {tx_r[30:0], 1'b0};
        end else if (&wcnt_inc_s) begin
          // Timeout: skip the frame entirely, CS still released via HOLD.
          state_s = ST_HOLD;
          err_s   = 1'b1;
        end else begin
          wcnt_s = wcnt_inc_s;
        end
      end

      ST_SHIFT: begin
        if (div_r != DIV_LAST) begin
          div_s = div_r + 8'd1;
        end else begin
          div_s = 8'd0;
          if (!sclk_r) begin
            sclk_s = 1'b1;
          end else begin
            // Last cycle of the high phase: sample DOUT for data bytes.
            if (bit_r >= 5'd8) begin
              rx_s = {rx_r[22:0], rdy_sync_r};
            end else begin
              rx_s = rx_r;
            end
            if (bit_r == bit_last_s) begin
              state_s = ST_HOLD;
            end else begin
              bit_s  = bit_r + 5'd1;
              sclk_s = 1'b0;
              din_s  = tx_r[31];
              tx_s   = {tx_r[30:0], 1'b0};
            end
          end
        end
      end

      ST_HOLD: begin
        if (div_r == DIV_LAST) begin
          div_s   = 8'd0;
          cs_s    = 1'b1;
          state_s = ST_GAP;
        end else begin
          div_s = div_r + 8'd1;
        end
      end

      ST_GAP: begin
        if (div_r == DIV_LAST) begin
          div_s   = 8'd0;
          state_s = ST_IDLE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          if (rd_r && (nbytes_r != 2'd0) && !err_r) begin
            rdata_s = rx_r;
          end else begin
            rdata_s = rdata_r;
          end
        end else begin
          div_s = div_r + 8'd1;
        end
      end

      default: begin
        state_s = ST_IDLE;
        cs_s    = 1'b1;
        sclk_s  = 1'b1;
        din_s   = 1'b1;
        busy_s  = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      div_r    <= 8'd0;
      bit_r    <= 5'd0;
      wcnt_r   <= '0;
      tx_r     <= 32'h00000000;
      rx_r     <= 24'h000000;
      nbytes_r <= 2'd0;
      rd_r     <= 1'b0;
      wait_r   <= 1'b0;
      cs_r     <= 1'b1;
      sclk_r   <= 1'b1;
      din_r    <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      rdata_r  <= 24'h000000;
    end else begin
      state_r  <= state_s;
      div_r    <= div_s;
      bit_r    <= bit_s;
      wcnt_r   <= wcnt_s;
      tx_r     <= tx_s;
      rx_r     <= rx_s;
      nbytes_r <= nbytes_s;
      rd_r     <= rd_s;
      wait_r   <= wait_s;
      cs_r     <= cs_s;
      sclk_r   <= sclk_s;
      din_r    <= din_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      err_r    <= err_s;
      rdata_r  <= rdata_s;
    end
  end

  assign U18_CS    = cs_r;
  assign U18_SCLK  = sclk_r;
  assign U18_DIN   = din_r;
  assign U18_CLK   = 1'b0;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.err   = err_r;
  assign bus.rdata = rdata_r;

endmodule

// File: tb/tb_ad7794_spi_master.sv
// Directed bench for ad7794_spi_master: write, read, RDY wait, timeout,
// ignored starts, mid-frame reset and back-to-back command-only frames.
// Instance a uses the default timeout width, instance b a 6-bit one.
module tb_ad7794_spi_master;

  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  logic start = 1'b0;
  logic [7:0]  cmd = 8'h00;
  logic [23:0] wdata = 24'h000000;
  logic [1:0]  nbytes = 2'd0;
  logic rd = 1'b0;
  logic wait_rdy = 1'b0;

  ad7794_spi_master_if bus_a ();
  ad7794_spi_master_if bus_b ();

  logic cs_a, sclk_a, din_a, mclk_a;
  logic cs_b, sclk_b, din_b, mclk_b;
  logic adc_dout;

  assign bus_a.start    = start & ~sel;
  assign bus_a.cmd      = cmd;
  assign bus_a.wdata    = wdata;
  assign bus_a.nbytes   = nbytes;
  assign bus_a.rd       = rd;
  assign bus_a.wait_rdy = wait_rdy;
  assign bus_b.start    = start & sel;
  assign bus_b.cmd      = cmd;
  assign bus_b.wdata    = wdata;
  assign bus_b.nbytes   = nbytes;
  assign bus_b.rd       = rd;
  assign bus_b.wait_rdy = wait_rdy;

  ad7794_spi_master #(.CLK_DIV(DIV), .TIMEOUT_W(20)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a),
    .U18_CS(cs_a), .U18_SCLK(sclk_a), .U18_DIN(din_a), .U18_CLK(mclk_a),
    .U18_DOUT_RDY(adc_dout)
  );

  ad7794_spi_master #(.CLK_DIV(DIV), .TIMEOUT_W(6)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b),
    .U18_CS(cs_b), .U18_SCLK(sclk_b), .U18_DIN(din_b), .U18_CLK(mclk_b),
    .U18_DOUT_RDY(adc_dout)
  );

  // Observe whichever instance is selected.
  logic cs_m, sclk_m, din_m, mclk_m, busy_m, done_m, err_m;
  logic [23:0] rdata_m;
  assign cs_m    = sel ? cs_b : cs_a;
  assign sclk_m  = sel ? sclk_b : sclk_a;
  assign din_m   = sel ? din_b : din_a;
  assign mclk_m  = sel ? mclk_b : mclk_a;
  assign busy_m  = sel ? bus_b.busy : bus_a.busy;
  assign done_m  = sel ? bus_b.done : bus_a.done;
  assign err_m   = sel ? bus_b.err : bus_a.err;
  assign rdata_m = sel ? bus_b.rdata : bus_a.rdata;

  always #5 clk = ~clk;

  // SCLK edge counters and DIN capture on rising SCLK (as the ADC samples).
  int rise_cnt = 0;
  int fall_cnt = 0;
  logic [31:0] din_sr = 32'h00000000;
  always @(posedge sclk_m) begin
    rise_cnt <= rise_cnt + 1;
    din_sr   <= {din_sr[30:0], din_m};
  end
  always @(negedge sclk_m) fall_cnt <= fall_cnt + 1;

  // ADC model: RDY high while held, else low until the first SCLK fall,
  // then one word bit per fall, MSB first.
  logic        adc_hold = 1'b1;
  logic [31:0] adc_word = 32'h00000000;
  int          fall_base = 0;
  int          adc_k;
  always_comb begin
    adc_k = fall_cnt - fall_base;
    if (adc_hold) adc_dout = 1'b1;
    else if (adc_k < 1) adc_dout = 1'b0;
    else if (adc_k > 32) adc_dout = 1'b1;
    else adc_dout = adc_word[32 - adc_k];
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a request and pulse start for one cycle; returns in cycle 1.
  task automatic launch(input logic s, input logic [7:0] c, input logic [23:0] w,
                        input logic [1:0] n, input logic r, input logic wr);
    sel = s; cmd = c; wdata = w; nbytes = n; rd = r; wait_rdy = wr;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Step cycle by cycle until done (bounded), recording frame timing.
  task automatic run_txn(input int limit, input bit poke, input int rdy_at,
                         output int done_cyc, output int first_lo, output int last_lo,
                         output int first_fall, output logic busy1, output logic err1,
                         output logic err_d);
    int cyc = 1;
    done_cyc = -1; first_lo = -1; last_lo = -1; first_fall = -1;
    busy1 = busy_m; err1 = err_m; err_d = 1'bx;
    while (done_cyc < 0 && cyc <= limit) begin
      if (!cs_m && first_lo < 0) first_lo = cyc;
      if (!cs_m) last_lo = cyc;
      if (!sclk_m && first_fall < 0) first_fall = cyc;
      if (done_m) begin
        done_cyc = cyc;
        err_d = err_m;
      end else begin
        if (cyc == rdy_at) begin
          adc_hold = 1'b0;
          fall_base = fall_cnt;
        end
        start = poke && (cyc % 50 == 10);
        @(negedge clk);
        start = 1'b0;
        cyc++;
      end
    end
  endtask

  int d_cyc, f_lo, l_lo, f_fall, rb, fb, d_cyc2, f_lo2, l_lo2, f_fall2;
  logic b1, e1, ed;

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_value("rst_cs", cs_m, 1);
    check_value("rst_sclk", sclk_m, 1);
    check_value("rst_din", din_m, 1);
    check_value("rst_mclk", mclk_m, 0);
    check_value("rst_busy", busy_m, 0);
    check_value("rst_done", done_m, 0);
    check_value("rst_err", err_m, 0);
    check_value("rst_rdata", rdata_m, 0);

    // Write 0x10,0x40,0x12 with extra start pulses while busy
    rb = rise_cnt; adc_hold = 1'b0; adc_word = 32'h0; fall_base = fall_cnt;
    launch(1'b0, 8'h10, 24'h004012, 2'd2, 1'b0, 1'b0);
    run_txn(1000, 1'b1, -1, d_cyc, f_lo, l_lo, f_fall, b1, e1, ed);
    check_value("wr_busy1", b1, 1);
    check_value("wr_cs_first", f_lo, 1);
    check_value("wr_cs_last", l_lo, 200);
    check_value("wr_first_fall", f_fall, 5);
    check_value("wr_done_cyc", d_cyc, 205);
    check_value("wr_err", ed, 0);
    check_value("wr_rises", rise_cnt - rb, 24);
    check_value("wr_din", din_sr & 32'h00FFFFFF, 32'h00104012);
    check_value("wr_rdata", rdata_m, 0);
    repeat (4) @(negedge clk);
    check_value("no_queued_busy", busy_m, 0);
    check_value("no_queued_cs", cs_m, 1);

    // Read 3 bytes, ADC returns 0xA5C3F0
    rb = rise_cnt; adc_word = 32'h00A5C3F0; fall_base = fall_cnt;
    launch(1'b0, 8'h58, 24'h123456, 2'd3, 1'b1, 1'b0);
    run_txn(1000, 1'b0, -1, d_cyc, f_lo, l_lo, f_fall, b1, e1, ed);
    check_value("rd_done_cyc", d_cyc, 269);
    check_value("rd_rdata", rdata_m, 32'h00A5C3F0);
    check_value("rd_din", din_sr, 32'h58FFFFFF);
    check_value("rd_rises", rise_cnt - rb, 32);

    // Wait for RDY, driven low 500 cycles after CS falls
    repeat (3) @(negedge clk);
    rb = rise_cnt; adc_hold = 1'b1; adc_word = 32'h0;
    launch(1'b0, 8'h5C, 24'h000000, 2'd0, 1'b0, 1'b1);
    run_txn(2000, 1'b0, 501, d_cyc, f_lo, l_lo, f_fall, b1, e1, ed);
    check_value("wt_fall_window", (f_fall >= 502 && f_fall <= 504) ? 1 : 0, 1);
    check_value("wt_done_cyc", d_cyc - f_fall, 72);
    check_value("wt_err", ed, 0);
    check_value("wt_rises", rise_cnt - rb, 8);
    check_value("wt_rdata", rdata_m, 32'h00A5C3F0);

    // Back-to-back command-only frames, start asserted on done
    repeat (3) @(negedge clk);
    rb = rise_cnt; adc_hold = 1'b0; fall_base = fall_cnt;
    launch(1'b0, 8'hFF, 24'h000000, 2'd0, 1'b0, 1'b0);
    run_txn(1000, 1'b0, -1, d_cyc, f_lo, l_lo, f_fall, b1, e1, ed);
    check_value("b2b_done1", d_cyc, 77);
    check_value("b2b_rises1", rise_cnt - rb, 8);
    check_value("b2b_din1", din_sr & 32'h000000FF, 32'h000000FF);
    rb = rise_cnt;
    launch(1'b0, 8'hFF, 24'h000000, 2'd0, 1'b0, 1'b0);
    run_txn(1000, 1'b0, -1, d_cyc2, f_lo2, l_lo2, f_fall2, b1, e1, ed);
    check_value("b2b_done2", d_cyc2, 77);
    check_value("b2b_rises2", rise_cnt - rb, 8);
    check_value("b2b_cs_gap", (d_cyc - l_lo) + (f_lo2 - 1), DIV + 1);

    // Instance b: one-byte read then timeout with RDY held high
    repeat (3) @(negedge clk);
    sel = 1'b1;
    @(negedge clk);
    adc_hold = 1'b0; adc_word = 32'h003C0000; fall_base = fall_cnt;
    launch(1'b1, 8'h48, 24'h000000, 2'd1, 1'b1, 1'b0);
    run_txn(1000, 1'b0, -1, d_cyc, f_lo, l_lo, f_fall, b1, e1, ed);
    check_value("rd1_done_cyc", d_cyc, 141);
    check_value("rd1_rdata", rdata_m, 32'h0000003C);
    repeat (3) @(negedge clk);
    rb = rise_cnt; fb = fall_cnt; adc_hold = 1'b1;
    launch(1'b1, 8'h58, 24'h000000, 2'd3, 1'b1, 1'b1);
    run_txn(1000, 1'b0, -1, d_cyc, f_lo, l_lo, f_fall, b1, e1, ed);
    check_value("to_done_cyc", d_cyc, 76);
    check_value("to_err", ed, 1);
    check_value("to_rises", rise_cnt - rb, 0);
    check_value("to_falls", fall_cnt - fb, 0);
    check_value("to_rdata", rdata_m, 32'h0000003C);
    repeat (3) @(negedge clk);
    check_value("to_err_held", err_m, 1);
    adc_hold = 1'b0; fall_base = fall_cnt;
    launch(1'b1, 8'h10, 24'h000000, 2'd0, 1'b0, 1'b0);
    run_txn(1000, 1'b0, -1, d_cyc, f_lo, l_lo, f_fall, b1, e1, ed);
    check_value("to_err_clear", e1, 0);
    check_value("to_next_done", d_cyc, 77);

    // Reset asserted in the middle of a shifting frame
    repeat (3) @(negedge clk);
    sel = 1'b0;
    @(negedge clk);
    launch(1'b0, 8'h10, 24'h004012, 2'd2, 1'b0, 1'b0);
    repeat (59) @(negedge clk);
    for (int g = 0; g < 20 && sclk_m !== 1'b1; g++) @(negedge clk);
    check_value("mid_busy", busy_m, 1);
    check_value("mid_sclk_high", sclk_m, 1);
    rb = rise_cnt; fb = fall_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    check_value("mrst_cs", cs_m, 1);
    check_value("mrst_sclk", sclk_m, 1);
    check_value("mrst_din", din_m, 1);
    check_value("mrst_busy", busy_m, 0);
    check_value("mrst_done", done_m, 0);
    check_value("mrst_err", err_m, 0);
    check_value("mrst_rdata", rdata_m, 0);
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_value("mrst_rises", rise_cnt - rb, 0);
    check_value("mrst_falls", fall_cnt - fb, 0);
    check_value("mrst_idle", busy_m, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
